pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. It owns the run/halt/single-step state machine, detects load-use and branch-operand hazards against the decode stage, and issues stall, bubble and squash controls. It drives the decode stage's `wist` squash input and the PC-select/PC-write controls of fetch, and keeps cycle and retire counters for host debug.

---
 rtl/core_pkg.sv | 31 +++
 rtl/hazard_unit.sv | 37 +++
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: sequencing FSM states, the canonical NOP, the
// opcode constants decode also uses, and a register-match helper.
package core_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  localparam logic [6:0]  OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0]  OPC_STORE  = 7'b010_0011;
  localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0]  OPC_JAL    = 7'b110_1111;
  localparam logic [6:0]  OPC_JALR   = 7'b110_0111;
  localparam logic [6:0]  OPC_OP     = 7'b011_0011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0]  OPC_LUI    = 7'b011_0111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b001_0111;

  // A producer hits a source only if it really writes and its rd is not x0.
  function automatic logic rd_hit(input logic wreg, input logic [4:0] rd,
                                  input logic [4:0] rs);
    return wreg && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection for the decode stage.
//   hz_load : load in EX feeds a source of the instruction in ID
//   hz_br   : branch/JALR in ID reads a register still pending in EX or MEM
//             (decode compare has no forwarding; WB is write-first)
//   stall   : either hazard on a real, unsquashed decode instruction
module hazard_unit
  import core_pkg::*;
(
  input  logic       id_valid,
  input  logic       wist,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs2,
  input  logic       id_is_br,
  input  logic [4:0] ex_rd,
  input  logic       ex_wreg,
  input  logic       ex_rmm,
  input  logic [4:0] mem_rd,
  input  logic       mem_wreg,
  output logic       hz_load,
  output logic       hz_br,
  output logic       stall
);

  logic ex_rs1, ex_rs2, mem_rs1, mem_rs2;

  assign ex_rs1  = rd_hit(ex_wreg,  ex_rd,  id_rs1);
  assign ex_rs2  = rd_hit(ex_wreg,  ex_rd,  id_rs2);
  assign mem_rs1 = rd_hit(mem_wreg, mem_rd, id_rs1);
  assign mem_rs2 = rd_hit(mem_wreg, mem_rd, id_rs2);

  assign hz_load = ex_rmm & (ex_rs1 | (id_use_rs2 & ex_rs2));
  assign hz_br   = id_is_br & (ex_rs1 | mem_rs1 |
                               (id_use_rs2 & (ex_rs2 | mem_rs2)));
  assign stall   = id_valid & ~wist & (hz_load | hz_br);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: run/halt/single-step FSM, stall/bubble/
// squash generation and host debug counters.
// Ports:
//   clk, rst                      clock, async active-high reset
//   host_run/halt/step            host command pulses
//   id_* / ex_* / mem_*           decode sources and downstream producers
//   wb_wea                        retire strobe
//   pc_we, pc_sel_jump, if_id_we  fetch / IF-ID controls
//   wist, id_ex_bubble            squash of IF/ID, NOP into ID/EX
//   running, halted               registered state flags
//   cycle_cnt, retire_cnt         debug counters (hold in HALT)
module pipe_ctrl
  import core_pkg::*;
#(
  parameter int unsigned PC_W      = 11,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_run,
  input  logic             host_halt,
  input  logic             host_step,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs2,
  input  logic             id_is_br,
  input  logic             id_jump_valid,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic             ex_wreg,
  input  logic             mem_wreg,
  input  logic             ex_rmm,
  input  logic             wb_wea,
  output logic             pc_we,
  output logic             pc_sel_jump,
  output logic             if_id_we,
  output logic             wist,
  output logic             id_ex_bubble,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  if (DRAIN_CYC < 1 || PC_W < 2) begin : g_param_check
    $error("pipe_ctrl: DRAIN_CYC must be >= 1 and PC_W >= 2");
  end

  state_e         state_q, state_n;
  logic [DCW-1:0] drain_q, drain_n;
  logic           squash_q, fetch_en_q;
  logic           fetch_en, take;
  logic           hz_load, hz_br, stall;

  hazard_unit u_hz (
    .id_valid   (id_valid),
    .wist       (wist),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs2 (id_use_rs2),
    .id_is_br   (id_is_br),
    .ex_rd      (ex_rd),
    .ex_wreg    (ex_wreg),
    .ex_rmm     (ex_rmm),
    .mem_rd     (mem_rd),
    .mem_wreg   (mem_wreg),
    .hz_load    (hz_load),
    .hz_br      (hz_br),
    .stall      (stall)
  );

  // STEP leaves on the cycle its fetch is accepted, so being in STEP
  // already means the fetch has not been taken yet.
  assign fetch_en     = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign take         = id_jump_valid & ~stall;
  assign pc_we        = fetch_en & ~stall;
  assign pc_sel_jump  = take;
  assign if_id_we     = pc_we | take;
  assign id_ex_bubble = stall | ~id_valid;
  // Registered only: decode gates on wist, so no loop back through ID.
  assign wist         = squash_q | ~fetch_en_q;

  always_comb begin
    state_n = state_q;
    drain_n = drain_q;
    case (state_q)
      ST_HALT: begin
        if (host_run)       state_n = ST_RUN;
        else if (host_step) state_n = ST_STEP;
      end
      ST_RUN: begin
        if (host_halt) begin
          state_n = ST_DRAIN;
          drain_n = DCW'(DRAIN_CYC - 1);
        end
      end
      ST_STEP: begin
        if (pc_we) begin
          state_n = ST_DRAIN;
          drain_n = DCW'(DRAIN_CYC - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_n = ST_HALT;
        else               drain_n = drain_q - DCW'(1);
      end
      default: state_n = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HALT;
      drain_q    <= '0;
      squash_q   <= 1'b0;
      fetch_en_q <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b1;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      state_q    <= state_n;
      drain_q    <= drain_n;
      squash_q   <= take;
      fetch_en_q <= fetch_en;
      running    <= (state_q == ST_RUN);
      halted     <= (state_q == ST_HALT);
      if (state_q != ST_HALT) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (wb_wea) retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_run, host_halt, host_step;
  logic        id_valid, id_use_rs2, id_is_br, id_jump_valid;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        ex_wreg, mem_wreg, ex_rmm, wb_wea;
  logic        pc_we, pc_sel_jump, if_id_we, wist, id_ex_bubble;
  logic        running, halted;
  logic [31:0] cycle_cnt, retire_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  // expected counters, advanced by the bench from its own view of the state
  bit          busy = 1'b0;
  logic [31:0] exp_cyc = '0;
  logic [31:0] exp_ret = '0;

  pipe_ctrl #(.PC_W(11), .DRAIN_CYC(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .host_run(host_run), .host_halt(host_halt), .host_step(host_step),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_is_br(id_is_br),
    .id_jump_valid(id_jump_valid),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_wreg(ex_wreg), .mem_wreg(mem_wreg),
    .ex_rmm(ex_rmm), .wb_wea(wb_wea),
    .pc_we(pc_we), .pc_sel_jump(pc_sel_jump), .if_id_we(if_id_we),
    .wist(wist), .id_ex_bubble(id_ex_bubble),
    .running(running), .halted(halted),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    if (busy) begin
      exp_cyc++;
      if (wb_wea) exp_ret++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    host_run = 0; host_halt = 0; host_step = 0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0;
    id_is_br = 0; id_jump_valid = 0;
    ex_rd = 0; mem_rd = 0; ex_wreg = 0; mem_wreg = 0; ex_rmm = 0;
    wb_wea = 0;
  endtask

  task automatic chk_ctl(input string tag, input logic pw, input logic sj,
                         input logic iw, input logic bb);
    #1;
    chk({tag, ".pc_we"},        32'(pc_we),        32'(pw));
    chk({tag, ".pc_sel_jump"},  32'(pc_sel_jump),  32'(sj));
    chk({tag, ".if_id_we"},     32'(if_id_we),     32'(iw));
    chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(bb));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".cycle_cnt"},  cycle_cnt,  exp_cyc);
    chk({tag, ".retire_cnt"}, retire_cnt, exp_ret);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    tick(); tick();
    // reset state
    chk_ctl("rst", 0, 0, 0, 1);
    chk("rst.wist", 32'(wist), 1);
    chk("rst.running", 32'(running), 0);
    chk("rst.halted", 32'(halted), 1);
    chk_cnt("rst");

    rst = 0;
    wb_wea = 1;                // retire strobe ignored in HALT
    tick(); tick();
    wb_wea = 0;
    chk_cnt("halt_hold");

    // host_run: RUN after the edge, flags one cycle later, wist one cycle
    host_run = 1;
    tick();
    host_run = 0; busy = 1;
    chk_ctl("run0", 1, 0, 1, 1);
    chk("run0.wist", 32'(wist), 1);
    chk("run0.running", 32'(running), 0);
    tick();
    chk("run1.running", 32'(running), 1);
    chk("run1.halted", 32'(halted), 0);
    chk("run1.wist", 32'(wist), 0);
    chk_cnt("run1");

    // load-use: lw x5 in EX, add x6,x5,x1 in ID -> one stall cycle
    id_valid = 1; id_rs1 = 5; id_rs2 = 1; id_use_rs2 = 1;
    ex_rd = 5; ex_wreg = 1; ex_rmm = 1;
    chk_ctl("lu_stall", 0, 0, 0, 1);
    tick();
    ex_rd = 0; ex_wreg = 0; ex_rmm = 0; mem_rd = 5; mem_wreg = 1;
    chk_ctl("lu_go", 1, 0, 1, 0);
    // load to x0 is not a hazard
    ex_rd = 0; ex_wreg = 1; ex_rmm = 1; id_rs1 = 0; mem_wreg = 0;
    chk_ctl("lu_x0", 1, 0, 1, 0);
    // rs2 match when rs2 is not read: no stall
    ex_rd = 9; id_rs1 = 3; id_rs2 = 9; id_use_rs2 = 0;
    chk_ctl("lu_nors2", 1, 0, 1, 0);
    id_use_rs2 = 1;
    chk_ctl("lu_rs2", 0, 0, 0, 1);
    ex_wreg = 0; ex_rmm = 0; ex_rd = 0;
    tick();

    // beq x7,x8 with x7 in EX: two stalls, then taken, then squash slot
    id_valid = 1; id_is_br = 1; id_rs1 = 7; id_rs2 = 8; id_use_rs2 = 1;
    id_jump_valid = 1; ex_rd = 7; ex_wreg = 1;
    chk_ctl("br_ex", 0, 0, 0, 1);
    tick();
    ex_rd = 0; ex_wreg = 0; mem_rd = 7; mem_wreg = 1;
    chk_ctl("br_mem", 0, 0, 0, 1);
    tick();
    mem_wreg = 0; mem_rd = 0;
    chk_ctl("br_take", 1, 1, 1, 0);
    tick();
    id_is_br = 0; id_jump_valid = 0;
    chk("br_sq.wist", 32'(wist), 1);
    // squashed slot cannot stall even on a load-use match
    id_rs1 = 4; ex_rd = 4; ex_wreg = 1; ex_rmm = 1;
    chk_ctl("br_sq", 1, 0, 1, 0);
    ex_wreg = 0; ex_rmm = 0; ex_rd = 0;
    tick();
    chk("br_sq_end.wist", 32'(wist), 0);

    // branch reading x0 with producers targeting x0: no stall
    id_is_br = 1; id_rs1 = 0; id_rs2 = 0; mem_wreg = 1; ex_wreg = 1;
    chk_ctl("br_x0", 1, 0, 1, 0);
    id_is_br = 0; mem_wreg = 0; ex_wreg = 0;

    // jal, no hazard: redirect now, squash next cycle
    id_jump_valid = 1;
    chk_ctl("jal", 1, 1, 1, 0);
    tick();
    id_jump_valid = 0;
    chk("jal_sq.wist", 32'(wist), 1);
    tick();
    chk("jal_done.wist", 32'(wist), 0);
    id_valid = 0;

    // host_halt: 4 DRAIN cycles, two retires during drain
    host_halt = 1;
    tick();                     // -> DRAIN (3)
    host_halt = 0;
    chk_ctl("drain0", 0, 0, 0, 1);
    wb_wea = 1;
    tick();                     // (2)
    host_run = 1;               // ignored in DRAIN
    tick();                     // (1)
    host_run = 0; wb_wea = 0;
    chk_ctl("drain_norun", 0, 0, 0, 1);
    tick();                     // (0)
    tick();                     // -> HALT
    busy = 0;
    chk("drain_end.halted", 32'(halted), 0);
    tick();
    chk("halt.halted", 32'(halted), 1);
    chk("halt.running", 32'(running), 0);
    chk_cnt("halt");

    // single step: one fetch, 4 drain cycles, cycle_cnt +5, retire +1
    host_step = 1;
    tick();                     // -> STEP
    host_step = 0; busy = 1;
    chk_ctl("step", 1, 0, 1, 1);
    tick();                     // -> DRAIN
    chk_ctl("step_drain", 0, 0, 0, 1);
    tick();
    wb_wea = 1;
    tick();
    wb_wea = 0;
    tick();
    tick();                     // -> HALT
    busy = 0;
    tick();
    chk("step.halted", 32'(halted), 1);
    chk_cnt("step");

    // run and step together: run wins, fetch continues past one cycle
    host_run = 1; host_step = 1;
    tick();
    host_run = 0; host_step = 0; busy = 1;
    tick();
    chk_ctl("runstep", 1, 0, 1, 1);
    chk("runstep.running", 32'(running), 1);

    // halt then reset 2 cycles into DRAIN
    host_halt = 1;
    tick();
    host_halt = 0;
    tick(); tick();
    rst = 1;
    busy = 0; exp_cyc = '0; exp_ret = '0;
    chk_ctl("arst", 0, 0, 0, 1);
    chk("arst.wist", 32'(wist), 1);
    chk("arst.running", 32'(running), 0);
    chk("arst.halted", 32'(halted), 1);
    chk_cnt("arst");
    tick();
    rst = 0;
    tick();
    host_run = 1;
    tick();
    host_run = 0; busy = 1;
    chk_ctl("resume", 1, 0, 1, 1);
    tick();
    chk("resume.running", 32'(running), 1);
    chk("resume.wist", 32'(wist), 0);
    chk_cnt("resume");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
